// File: rtl/joy_pkg.sv
// Shared types and constants for the joystick direction decoder.
package joy_pkg;
  localparam int ADC_W = 10;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_ACCUM    = 2'd2,
    S_CLASSIFY = 2'd3
  } state_t;
endpackage

// File: rtl/joy_axis_classifier.sv
// One axis: dead-zone classification into pos/neg levels plus press/auto-repeat events.
// Optional release hysteresis under JOY_HYST_EN.
module joy_axis_classifier
  import joy_pkg::*;
#(
  parameter int CENTER        = 512,
  parameter int DEADZONE      = 128,
  parameter int REPEAT_FRAMES = 50
`ifdef JOY_HYST_EN
  ,parameter int HYST         = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] avg,
  input  logic             strobe,
  output logic             pos_level,
  output logic             neg_level,
  output logic             pos_event,
  output logic             neg_event
);
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [ADC_W-1:0] HI   = ADC_W'(CENTER + DEADZONE);
  localparam logic [ADC_W-1:0] LO   = ADC_W'(CENTER - DEADZONE);
  localparam logic [RW-1:0]    RMAX = RW'(REPEAT_FRAMES - 1);
`ifdef JOY_HYST_EN
  localparam logic [ADC_W-1:0] HI_REL = ADC_W'(CENTER + DEADZONE - HYST);
  localparam logic [ADC_W-1:0] LO_REL = ADC_W'(CENTER - DEADZONE + HYST);
`endif

  // index 0 = positive direction, 1 = negative direction
  logic [1:0]         lvl, lvl_nxt, evt;
  logic [1:0][RW-1:0] hold;

  always_comb begin
    lvl_nxt[0] = avg > HI;
    lvl_nxt[1] = avg < LO;
`ifdef JOY_HYST_EN
    // an active level is kept until the axis falls strictly inside the narrower band
    if (lvl[0] && avg >= HI_REL) lvl_nxt[0] = 1'b1;
    if (lvl[1] && avg <= LO_REL) lvl_nxt[1] = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl  <= '0;
      evt  <= '0;
      hold <= '0;
    end else begin
      evt <= '0;
      if (strobe) begin
        for (int i = 0; i < 2; i++) begin
          lvl[i] <= lvl_nxt[i];
          if (lvl_nxt[i] && !lvl[i]) begin
            evt[i]  <= 1'b1;
            hold[i] <= '0;
          end else if (lvl_nxt[i]) begin
            if (hold[i] == RMAX) begin
              evt[i]  <= 1'b1;
              hold[i] <= '0;
            end else begin
              hold[i] <= hold[i] + 1'b1;
            end
          end else begin
            hold[i] <= '0;
          end
        end
      end
    end
  end

  assign pos_level = lvl[0];
  assign neg_level = lvl[1];
  assign pos_event = evt[0];
  assign neg_event = evt[1];
endmodule

// File: rtl/joystick_direction_decoder.sv
// Paces MCP3008 conversions, box-car averages X/Y pairs and decodes joystick directions.
// Optional release hysteresis under JOY_HYST_EN.
module joystick_direction_decoder
  import joy_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int AVG_LOG2       = 2,
  parameter int CENTER         = 512,
  parameter int DEADZONE       = 128,
  parameter int REPEAT_FRAMES  = 50,
  parameter int TIMEOUT_CYCLES = 1024
`ifdef JOY_HYST_EN
  ,parameter int HYST          = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             adc_start,
  input  logic [ADC_W-1:0] adc_x,
  input  logic [ADC_W-1:0] adc_y,
  input  logic             adc_valid,
  output logic [ADC_W-1:0] x_avg,
  output logic [ADC_W-1:0] y_avg,
  output logic             avg_valid,
  output logic [3:0]       dir_level,
  output logic [3:0]       dir_event,
  output logic             adc_timeout
);
  localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = ADC_W + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [TW-1:0] TMAX = TW'(SAMPLE_DIV - 1);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] NMAX = CW'((1 << AVG_LOG2) - 1);

  state_t           state;
  logic [TW-1:0]    timer;
  logic [WW-1:0]    wait_cnt;
  logic [ADC_W-1:0] cap_x, cap_y;
  logic [AW-1:0]    acc_x, acc_y, sum_x, sum_y;
  logic [CW-1:0]    cnt;
  logic [ADC_W-1:0] avg_x_nxt, avg_y_nxt;
  logic             tick, frame_done;
  logic             x_pos, x_neg, y_pos, y_neg;
  logic             x_pos_ev, x_neg_ev, y_pos_ev, y_neg_ev;

  assign tick       = enable && (timer == TMAX);
  assign sum_x      = acc_x + AW'(cap_x);
  assign sum_y      = acc_y + AW'(cap_y);
  assign avg_x_nxt  = ADC_W'(sum_x >> AVG_LOG2);
  assign avg_y_nxt  = ADC_W'(sum_y >> AVG_LOG2);
  // classifiers see the fresh average on the same edge it is latched
  assign frame_done = (state == S_ACCUM) && (cnt == NMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           timer <= '0;
    else if (!enable)     timer <= '0;
    else if (timer == TMAX) timer <= '0;
    else                  timer <= timer + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      adc_start   <= 1'b0;
      wait_cnt    <= '0;
      cap_x       <= '0;
      cap_y       <= '0;
      acc_x       <= '0;
      acc_y       <= '0;
      cnt         <= '0;
      x_avg       <= '0;
      y_avg       <= '0;
      avg_valid   <= 1'b0;
      adc_timeout <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      avg_valid <= frame_done;
      case (state)
        S_IDLE: if (tick) begin
          adc_start <= 1'b1;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (adc_valid) begin
            cap_x       <= adc_x;
            cap_y       <= adc_y;
            adc_timeout <= 1'b0;
            state       <= S_ACCUM;
          end else if (wait_cnt == WMAX) begin
            adc_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          if (cnt == NMAX) begin
            x_avg <= avg_x_nxt;
            y_avg <= avg_y_nxt;
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
            state <= S_CLASSIFY;
          end else begin
            acc_x <= sum_x;
            acc_y <= sum_y;
            cnt   <= cnt + 1'b1;
            state <= S_IDLE;
          end
        end
        S_CLASSIFY: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  joy_axis_classifier #(
    .CENTER(CENTER), .DEADZONE(DEADZONE), .REPEAT_FRAMES(REPEAT_FRAMES)
`ifdef JOY_HYST_EN
    ,.HYST(HYST)
`endif
  ) u_x (
    .clk(clk), .reset(reset), .avg(avg_x_nxt), .strobe(frame_done),
    .pos_level(x_pos), .neg_level(x_neg), .pos_event(x_pos_ev), .neg_event(x_neg_ev)
  );

  joy_axis_classifier #(
    .CENTER(CENTER), .DEADZONE(DEADZONE), .REPEAT_FRAMES(REPEAT_FRAMES)
`ifdef JOY_HYST_EN
    ,.HYST(HYST)
`endif
  ) u_y (
    .clk(clk), .reset(reset), .avg(avg_y_nxt), .strobe(frame_done),
    .pos_level(y_pos), .neg_level(y_neg), .pos_event(y_pos_ev), .neg_event(y_neg_ev)
  );

  assign dir_level[DIR_UP]    = y_pos;
  assign dir_level[DIR_DOWN]  = y_neg;
  assign dir_level[DIR_LEFT]  = x_neg;
  assign dir_level[DIR_RIGHT] = x_pos;
  assign dir_event[DIR_UP]    = y_pos_ev;
  assign dir_event[DIR_DOWN]  = y_neg_ev;
  assign dir_event[DIR_LEFT]  = x_neg_ev;
  assign dir_event[DIR_RIGHT] = x_pos_ev;
endmodule

// File: doc/joystick_direction_decoder.md
Name: joystick_direction_decoder

Overview:
- Sits between the MCP3008 SPI driver and the UI/menu logic.
- Paces ADC conversions by pulsing the driver's start, captures each X/Y pair on data_valid, and box-car averages 2^AVG_LOG2 pairs.
- Classifies each averaged pair against a centre dead-zone into up/down/left/right levels, plus one-cycle press events with auto-repeat.
- Flags a missing ADC response.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- SAMPLE_HZ, 1000, conversion request rate; SAMPLE_DIV = CLK_HZ/SAMPLE_HZ (must be >= 2).
- AVG_LOG2, 2, log2 of samples per average (0..4).
- CENTER, 512, rest-position code.
- DEADZONE, 128, half-width of the neutral band. Requires DEADZONE < CENTER and CENTER+DEADZONE <= 1023.
- REPEAT_FRAMES, 50, averaged frames a direction must stay held between repeat events (>= 1).
- TIMEOUT_CYCLES, 1024, clk cycles to wait for adc_valid after adc_start.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- enable  in  1  level; 1 allows new conversion requests.
- adc_start  out  1  one-cycle request to the ADC driver.
- adc_x  in  10  X code from the driver, valid with adc_valid.
- adc_y  in  10  Y code from the driver, valid with adc_valid.
- adc_valid  in  1  one-cycle strobe from the driver.
- x_avg  out  10  averaged X.
- y_avg  out  10  averaged Y.
- avg_valid  out  1  one-cycle strobe when x_avg/y_avg update.
- dir_level  out  4  {right,left,down,up} current direction levels.
- dir_event  out  4  one-cycle press/repeat pulses, same bit order.
- adc_timeout  out  1  sticky fault flag.

Behaviour:
- Reset: all outputs, accumulators, counters and the timer are 0; FSM is S_IDLE. The clock/reset choice (clock clk; reset reset, asynchronous, active-low) is already decided.
- Sample timer: counts 0..SAMPLE_DIV-1 while enable=1. Held at 0 while enable=0.
- Tick: terminal count.
  - If FSM is in S_IDLE, adc_start=1 for exactly that one cycle and FSM goes to S_WAIT.
  - Otherwise the tick is dropped (no queuing).
- FSM states:
  - S_IDLE: wait for tick.
  - S_WAIT:
    - adc_valid=1: capture adc_x/adc_y, clear adc_timeout, go to S_ACCUM.
    - Wait counter reaches TIMEOUT_CYCLES: set adc_timeout, go to S_IDLE; accumulators unchanged.
  - S_ACCUM:
    - accX += x, accY += y (width 10+AVG_LOG2, no overflow possible); sample count += 1.
    - If count wraps at 2^AVG_LOG2: latch x_avg = accX>>AVG_LOG2 (likewise y), clear accumulators and count, go to S_CLASSIFY.
    - Otherwise go to S_IDLE.
  - S_CLASSIFY:
    - Registered outputs update on the S_CLASSIFY edge: avg_valid=1 for one cycle, dir_level/dir_event per the classification rules below.
    - Go to S_IDLE.
- Latency: adc_valid to avg_valid is 2 cycles on the completing sample.
- adc_valid outside S_WAIT is ignored. adc_valid in the same cycle the timeout expires: valid wins.
- enable falling during S_WAIT: the transaction completes normally; no further starts. dir_level holds its last value.
- Classification (per axis, strict compares):
  - right = x_avg > CENTER+DEADZONE; left = x_avg < CENTER-DEADZONE.
  - up = y_avg > CENTER+DEADZONE; down = y_avg < CENTER-DEADZONE.
  - Opposite bits are never both 1. Diagonals set two bits.
- Events (per bit):
  - 0->1 transition of the level: pulse dir_event and clear that bit's hold counter.
  - While the level stays 1: hold counter +1 per S_CLASSIFY; on reaching REPEAT_FRAMES, pulse again and clear.
  - Level 0: counter held at 0.
- Reset mid-operation: immediate return to reset state. adc_start never glitches high.

Optional Feature:
- Macro JOY_HYST_EN.
- Defined: adds parameter HYST (default 32, < DEADZONE).
  - An active direction releases only when the axis returns strictly inside CENTER±(DEADZONE-HYST).
  - Assertion thresholds are unchanged.
- Undefined: a single threshold pair; the level follows the classification rules exactly.

Decomposition:
- Package joy_pkg:
  - FSM state enum (S_IDLE, S_WAIT, S_ACCUM, S_CLASSIFY).
  - ADC_W=10.
  - Direction bit indices DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
- Sub-module joy_axis_classifier, instantiated twice (X, Y):
  - Inputs: avg, strobe.
  - Outputs: pos/neg levels and events, including hysteresis and repeat counters.

Test Plan:
- Params CLK_HZ=1000, SAMPLE_HZ=100, AVG_LOG2=2, REPEAT_FRAMES=3. Model driver answers 5 cycles after start with x=y=512 -> adc_start every 10 cycles; avg_valid every 4th sample; x_avg=y_avg=512; dir_level=0, no events.
- Samples x=700,700,700,700 -> x_avg=700, dir_level=4'b1000, dir_event=4'b1000 pulse once.
- Hold x=700 for 7 more frames -> repeat pulses on frames 3 and 6 after the press; no pulse otherwise.
- Samples x=640,641,640,641 -> x_avg=640 (truncated 2562>>2), not > 640, no right.
- Driver silent after start, TIMEOUT_CYCLES=8 -> adc_timeout=1 eight cycles after start. Next valid response clears it; accumulation resumes with the prior partial sum.
- Reset asserted while in S_WAIT with 2 samples accumulated -> all outputs 0. After release, the first avg_valid needs 4 fresh samples.
- JOY_HYST_EN with HYST=32, x: 700 -> 630 -> 600 -> right stays set at 630 and clears at 600.
